// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, ALU source selects and ALUOp.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch  = 4'd0;
  localparam state_t StDecode = 4'd1;
  localparam state_t StExecR  = 4'd2;
  localparam state_t StExecI  = 4'd3;
  localparam state_t StAddr   = 4'd4;
  localparam state_t StMemRd  = 4'd5;
  localparam state_t StMemWr  = 4'd6;
  localparam state_t StWbAlu  = 4'd7;
  localparam state_t StWbMem  = 4'd8;
  localparam state_t StBranch = 4'd9;
  localparam state_t StTrap   = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request and flags the cycle on which the
// request runs out of budget.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  input  logic ready,
  output logic expire
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  // The cycle whose increment would reach MEM_TIMEOUT-1 is the last one allowed to wait.
  localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT - 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            waiting;

  assign waiting = req & ~ready;
  assign expire  = waiting & (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV64 controller: sequences fetch/decode/execute/memory/writeback over a shared
// datapath with a req/ready memory handshake, sticky traps and a retired-instruction counter.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          SUPPORT_BNE  = 1'b1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2:0]              funct3,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_addr_sel,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic                    illegal,
  output logic                    timeout,
  output logic [3:0]              state_o,
  output logic [CNT_WIDTH-1:0]    instret
);

  state_t               state_q, state_d;
  logic                 illegal_q, timeout_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 set_illegal, retire, expire, timer_clr, branch_taken;

  assign branch_taken = ((funct3 == F3_BEQ) & zero) |
                        (SUPPORT_BNE & (funct3 == F3_BNE) & ~zero);

  // Wait count restarts whenever the state changes or a transfer completes.
  assign timer_clr = (state_d != state_q) | mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .req   (mem_req),
    .ready (mem_ready),
    .expire(expire)
  );

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    retire      = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (expire) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        case (opcode)
          OPCODE_WIDTH'(OP_R):      state_d = StExecR;
          OPCODE_WIDTH'(OP_I):      state_d = StExecI;
          OPCODE_WIDTH'(OP_LOAD),
          OPCODE_WIDTH'(OP_STORE):  state_d = StAddr;
          OPCODE_WIDTH'(OP_BRANCH): state_d = StBranch;
          default: begin
            state_d     = StTrap;
            set_illegal = 1'b1;
          end
        endcase
      end
      StExecR, StExecI: state_d = StWbAlu;
      StAddr: state_d = (opcode == OPCODE_WIDTH'(OP_LOAD)) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready) begin
          state_d = StWbMem;
        end else if (expire) begin
          state_d = StTrap;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (expire) begin
          state_d = StTrap;
        end
      end
      StWbAlu, StWbMem, StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Outputs are forced low while reset is held so an in-flight request drops immediately.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALUOP_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALUOP_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 1'b0;
          end
        end
        StDecode: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALUOP_ADD;
        end
        StExecR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALUOP_FUNCT;
        end
        StExecI: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALUOP_FUNCT;
        end
        StAddr: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALUOP_ADD;
        end
        StMemRd: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
        end
        StMemWr: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        StWbAlu: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b0;
        end
        StWbMem: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StBranch: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
          alu_op    = ALUOP_BRANCH;
          pc_src    = 1'b1;
          pc_write  = branch_taken;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_WIDTH'(1);
      end
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state_o = state_q;
  assign instret = instret_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Controller FSM for the multi-cycle generation of the RV64 processor core. It replaces the single-cycle main_control plus the branch AND gate. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one shared datapath. A req/ready handshake lets instruction and data memory have variable latency. The block also adds BNE support, a memory-timeout trap, an illegal-opcode trap and a retired-instruction counter.

Parameters:
OPCODE_WIDTH, 7, width of the opcode field.
MEM_TIMEOUT, 16, maximum wait cycles per memory request before trapping (must be at least 2).
SUPPORT_BNE, 1, 1 = the BRANCH state honours funct3=001 (bne); 0 = only beq is taken.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  OPCODE_WIDTH  instruction-register bits [6:0]
funct3  in  3  instruction-register bits [14:12]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req
mem_addr_sel  out  1  0 = PC, 1 = ALUOut
ir_write  out  1  load the instruction register
pc_write  out  1  load the PC
pc_src  out  1  0 = ALU result, 1 = ALUOut (branch target)
alu_src_a  out  2  0 = PC, 1 = rs1, 2 = oldPC
alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = imm
alu_op  out  2  same encoding as the ALU_CONTROL ALUOp input
reg_write  out  1  register-file write enable
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
illegal  out  1  sticky: unknown opcode
timeout  out  1  sticky: memory timeout
state_o  out  4  current state, for debug
instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=FETCH, wait counter=0, instret=0, illegal=0, timeout=0, and every other output is forced to 0.
- Outputs are combinational from the state plus mem_ready, zero and funct3. The states are listed below.
- FETCH: mem_req=1, addr_sel=0, src_a=0, src_b=1, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: src_a=2, src_b=2, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - anything else -> TRAP with illegal=1
- EXEC_R: src_a=1, src_b=0, alu_op=10, then WB_ALU.
- EXEC_I: src_a=1, src_b=2, alu_op=10, then WB_ALU.
- ADDR: src_a=1, src_b=2, alu_op=00. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_req=1, addr_sel=1. On mem_ready -> WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On mem_ready -> FETCH and retire.
- WB_ALU: reg_write=1, mem_to_reg=0, then FETCH and retire.
- WB_MEM: reg_write=1, mem_to_reg=1, then FETCH and retire.
- BRANCH: src_a=1, src_b=0, alu_op=01, pc_src=1, then FETCH and retire.
  - pc_write = (funct3==000 & zero) | (SUPPORT_BNE & funct3==001 & ~zero).
- TRAP: all enables 0, mem_req=0. Held until reset.
- Latency at zero wait states: R/I 4 cycles, load 5, store 4, branch 3. Each wait cycle adds 1.
- Handshake:
  - mem_req and all qualifiers stay stable until mem_ready.
  - mem_ready while mem_req=0 is ignored.
  - Exactly one transfer occurs per request.
- Wait counter:
  - Clears on state entry and on mem_ready.
  - Increments each cycle mem_req=1 & mem_ready=0.
  - Reaching MEM_TIMEOUT-1 without ready -> TRAP with timeout=1.
  - mem_ready in the same cycle as the limit wins: no trap.
- instret increments by 1 on every retire and wraps modulo 2^CNT_WIDTH. It is never incremented in TRAP.
- Reset mid-operation aborts any request immediately. The first cycle after release is FETCH with mem_req=1.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4 bits);
  - the opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - the ALU-source encodings and the ALUOp constants.
- One sub-module, mem_wait_timer: the wait counter plus timeout compare, parametrised by MEM_TIMEOUT.

Test Plan:
1. mem_ready always 1, add (opcode 0110011) -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write in cycle 4; instret=1.
2. Load with mem_ready delayed 3 cycles in MEM_RD -> mem_req/addr_sel=1 stable for 4 cycles; WB_MEM at cycle 8; mem_to_reg=1.
3. beq with zero=1 -> pc_write=1, pc_src=1. Then bne with zero=1 and SUPPORT_BNE=1 -> pc_write=0. Then bne with zero=0 -> pc_write=1.
4. Opcode 1111111 -> TRAP after DECODE; illegal=1; all enables 0 for 20 cycles; instret unchanged.
5. MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 3 wait cycles with timeout=1. Repeat with ready on the limit cycle -> no trap.
6. rst asserted mid-MEM_WR -> mem_req and mem_we drop in the same cycle; instret=0; after release state_o=FETCH and mem_req=1.
